// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit with fixed-latency busy window.
// Optional build macro: MDU_DIV_ZERO_GUARD_EN (divide by zero leaves HI/LO untouched).
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, div_safe, q_mag, r_mag, quo, rem;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
  assign a_neg    = (op_q == OP_DIV) && a_q[31];
  assign b_neg    = (op_q == OP_DIV) && b_q[31];
  assign b_zero   = (b_q == '0);
  assign a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag    = b_neg ? (~b_q + 32'd1) : b_q;
  assign div_safe = b_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / div_safe;
  assign r_mag    = a_mag % div_safe;
  assign quo      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = op[1] ? DIV_N : MULT_N;
              state_d = BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            default: begin
              if (!b_zero) begin
                hi_d = rem;
                lo_d = quo;
              end else begin
`ifdef MDU_DIV_ZERO_GUARD_EN
                hi_d = hi_q;
                lo_d = lo_q;
`else
                hi_d = a_q;
                lo_d = '1;
`endif
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, compared when busy drops.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the first negedge with busy low after issue.
  task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n_busy, output bit held);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
    A     = $urandom;
    B     = $urandom;
    n_busy = 0;
    held   = 1'b1;
    while (busy === 1'b1 && n_busy < 40) begin
      n_busy++;
      if (HI !== m_hi || LO !== m_lo) held = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic res_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, p, q, rm;
    longint unsigned ua, ub, pu, qu, ru;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r.hi = m_hi;
    r.lo = m_lo;
    case (o)
      3'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'd1: begin pu = ua * ub; r.hi = pu[63:32]; r.lo = pu[31:0]; end
      3'd2: begin q = sa / sb; rm = sa % sb; r.hi = rm[31:0]; r.lo = q[31:0]; end
      default: begin qu = ua / ub; ru = ua % ub; r.hi = ru[31:0]; r.lo = qu[31:0]; end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", LO); end
    m_hi  = '0;
    m_lo  = '0;
    reset = 1'b1;
  endtask

  task automatic test_mult();
    res_t e;
    int   nb;
    bit   held;
    sb_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFA});
    drive_op(3'd0, 32'hFFFFFFFE, 32'd3, nb, held);
    e = sb_q.pop_front();
    checks++; if (nb !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    checks++; if (!held) begin errors++; $display("FAIL mult_hold: HI/LO changed during busy, got 0 want 1"); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL mult_hi: got %h want %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL mult_lo: got %h want %h", LO, e.lo); end
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic test_multu();
    res_t e;
    int   nb;
    bit   held;
    sb_q.push_back('{32'h00000001, 32'hFFFFFFFE});
    drive_op(3'd1, 32'hFFFFFFFF, 32'd2, nb, held);
    e = sb_q.pop_front();
    checks++; if (nb !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", nb); end
    checks++; if (!held) begin errors++; $display("FAIL multu_hold: HI/LO changed during busy"); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL multu_hi: got %h want %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL multu_lo: got %h want %h", LO, e.lo); end
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic test_div();
    logic [31:0] va [2] = '{32'hFFFFFFF9, 32'h80000000};
    logic [31:0] vb [2] = '{32'h00000002, 32'hFFFFFFFF};
    res_t        ve [2] = '{'{32'hFFFFFFFF, 32'hFFFFFFFD}, '{32'h00000000, 32'h80000000}};
    res_t e;
    int   nb;
    bit   held;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(ve[i]);
      drive_op(3'd2, va[i], vb[i], nb, held);
      e = sb_q.pop_front();
      checks++; if (nb !== 10) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d want 10", i, nb); end
      checks++; if (!held) begin errors++; $display("FAIL div%0d_hold: HI/LO changed during busy", i); end
      checks++; if (HI !== e.hi) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, HI, e.hi); end
      checks++; if (LO !== e.lo) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, LO, e.lo); end
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic test_divu_zero();
    res_t e;
    int   nb;
    bit   held;
`ifdef MDU_DIV_ZERO_GUARD_EN
    sb_q.push_back('{m_hi, m_lo});
`else
    sb_q.push_back('{32'h00000007, 32'hFFFFFFFF});
`endif
    drive_op(3'd3, 32'd7, 32'd0, nb, held);
    e = sb_q.pop_front();
    checks++; if (nb !== 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 10", nb); end
    checks++; if (!held) begin errors++; $display("FAIL divz_hold: HI/LO changed during busy"); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL divz_hi: got %h want %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL divz_lo: got %h want %h", LO, e.lo); end
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic test_mthi_mtlo();
    res_t e;
    int   nb;
    bit   held;
    sb_q.push_back('{32'h12345678, m_lo});
    drive_op(3'd4, 32'h12345678, 32'hDEADBEEF, nb, held);
    e = sb_q.pop_front();
    checks++; if (nb !== 0) begin errors++; $display("FAIL mthi_busy: got %0d busy cycles want 0", nb); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL mthi_hi: got %h want %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL mthi_lo: got %h want %h", LO, e.lo); end
    m_hi = e.hi;
    sb_q.push_back('{m_hi, 32'h9ABCDEF0});
    drive_op(3'd5, 32'h9ABCDEF0, 32'h0, nb, held);
    e = sb_q.pop_front();
    checks++; if (nb !== 0) begin errors++; $display("FAIL mtlo_busy: got %0d busy cycles want 0", nb); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL mtlo_hi: got %h want %h", HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL mtlo_lo: got %h want %h", LO, e.lo); end
    m_lo = e.lo;
  endtask

  task automatic test_noop();
    int nb;
    bit held;
    for (int o = 6; o < 8; o++) begin
      drive_op(3'(o), 32'hA5A5A5A5, 32'h5A5A5A5A, nb, held);
      checks++; if (nb !== 0) begin errors++; $display("FAIL noop%0d_busy: got %0d want 0", o, nb); end
      checks++; if (HI !== m_hi || LO !== m_lo)
        begin errors++; $display("FAIL noop%0d_hilo: got %h/%h want %h/%h", o, HI, LO, m_hi, m_lo); end
    end
  endtask

  task automatic test_back_to_back();
    res_t        e;
    int          nb;
    bit          held;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i == 1) b = 32'hFFFFFFFF;
      if (o[1] && b == '0) b = 32'd5;
      sb_q.push_back(model(o, a, b));
      drive_op(o, a, b, nb, held);
      e = sb_q.pop_front();
      checks++; if (nb !== (o[1] ? 10 : 5))
        begin errors++; $display("FAIL b2b%0d_busy_cycles: op %0d got %0d", i, o, nb); end
      checks++; if (HI !== e.hi || LO !== e.lo)
        begin errors++; $display("FAIL b2b%0d_hilo: op %0d A %h B %h got %h/%h want %h/%h", i, o, a, b, HI, LO, e.hi, e.lo); end
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    start = 1'b1;
    op    = 3'd2;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %0b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_async: got %0b want 0", busy); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0)
      begin errors++; $display("FAIL rmid_hilo_async: got %h/%h want 0/0", HI, LO); end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    nb = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL rmid_busy_after: got %0d busy cycles want 0", nb); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0)
      begin errors++; $display("FAIL rmid_hilo_after: got %h/%h want 0/0", HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_mthi_mtlo();
    test_noop();
    test_back_to_back();
    test_reset_mid();
    test_mult();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
